serial_frame_rx: RTL and testbench

Serial frame receiver: the consuming end of a single-bit `d` stream driven one bit-period at a time by upstream flops or a bench. It detects a start bit, samples `WIDTH` data bits LSB-first at bit-period centres, checks the stop bit, and presents the assembled word on a parallel output with a one-cycle valid strobe. It sits between a serial source and any parallel consumer in the flip-flop/sequential exercises.

---
 rtl/serial_frame_pkg.sv | 18 +
 rtl/serial_frame_rx_bit_timer.sv | 34 +++
 rtl/serial_frame_rx.sv | 109 ++++++++++
 tb/tb_serial_frame_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver.
//   rx_state_e        : receiver FSM state encoding (3-bit)
//   DEF_WIDTH         : default data bits per frame
//   DEF_CLKS_PER_BIT  : default clocks per bit period
package serial_frame_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/serial_frame_rx_bit_timer.sv
// Bit-period timer for the serial frame receiver.
//   clk        : clock
//   reset_sync : synchronous active-high reset
//   clear      : hold the count at zero (receiver idle)
//   half_mode  : tick after half a bit period instead of a full one
//   tick       : high in the cycle whose closing edge is a sampling point
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_sync,
    input  logic clear,
    input  logic half_mode,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // Tick decodes the registered count, so the edge that sees it is exactly
    // HALF (or CLKS_PER_BIT) edges after the clearing edge.
    assign tick = (cnt == (half_mode ? HALF_LAST : FULL_LAST));

    // Restarting on every tick re-aligns the full-period count to the
    // mid-bit sampling point found in half mode.
    always_ff @(posedge clk) begin
        if (reset_sync || clear || tick) cnt <= '0;
        else                             cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit 0, WIDTH data bits LSB-first, stop bit 1,
// each CLKS_PER_BIT clocks long, sampled at bit-period centres.
//   clk        : sole clock
//   reset_sync : synchronous active-high reset, priority over everything
//   d          : serial line, idle high
//   q_data     : last correctly framed word
//   q_valid    : one-cycle strobe, q_data just updated
//   frame_err  : one-cycle strobe, stop bit sampled low
//   busy       : high in every state except IDLE
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic             d,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int IW = $clog2(WIDTH + 1);

    rx_state_e        state;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    bit_idx;
    logic             tick;

    // Timer is held at zero while waiting for a start bit, so the edge that
    // detects the start leaves it at count 0.
    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .reset_sync (reset_sync),
        .clear      ((state == ST_IDLE) || (state == ST_WAIT_IDLE)),
        .half_mode  (state == ST_START),
        .tick       (tick)
    );

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            q_data    <= '0;
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            q_valid   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!d) begin
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (!d) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            // Start bit did not survive to mid-bit: glitch.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        // LSB arrives first, so new bits enter at the MSB.
                        shreg <= (shreg >> 1) | (WIDTH'(d) << (WIDTH - 1));
                        if (bit_idx == IW'(WIDTH - 1)) state <= ST_STOP;
                        else                           bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (d) begin
                            q_data  <= shreg;
                            q_valid <= 1'b1;
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    // A held-low line must go high before a new start counts.
                    if (d) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx. The line is described as a per-cycle
// bit stream; a sample-point reference model derives the expected strobes.
module tb_serial_frame_rx;

    localparam int W    = 8;
    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
    localparam int LAT  = HALF + (W + 1) * CPB + 1;

    logic         clk = 1'b0;
    logic         reset_sync = 1'b1;
    logic         d = 1'b1;
    logic [W-1:0] q_data;
    logic         q_valid, frame_err, busy;

    serial_frame_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .d          (d),
        .q_data     (q_data),
        .q_valid    (q_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int           cyc;
        bit           err;
        logic [W-1:0] data;
    } ev_t;

    ev_t          act_q[$], exp_q[$];
    bit           stim[$], rst_q[$];
    bit           busy_log[$];
    logic [W-1:0] qd_log[$];
    logic [W-1:0] model_q = '0;
    int           play_base;
    int           checks = 0, passed = 0;

    // Strobe monitor: the value seen at a negedge was registered at the
    // preceding posedge, whose number is cyc.
    always @(negedge clk) begin
        if (q_valid)   act_q.push_back('{cyc, 1'b0, q_data});
        if (frame_err) act_q.push_back('{cyc, 1'b1, q_data});
    end

    task automatic clear_stim();
        stim.delete(); rst_q.delete(); busy_log.delete(); qd_log.delete();
        act_q.delete(); exp_q.delete();
    endtask

    task automatic push_bits(input bit v, input int n);
        for (int i = 0; i < n; i++) begin stim.push_back(v); rst_q.push_back(1'b0); end
    endtask

    task automatic push_frame(input logic [W-1:0] data, input bit stop, input int gap);
        push_bits(1'b0, CPB);
        for (int i = 0; i < W; i++) push_bits(data[i], CPB);
        push_bits(stop, CPB);
        push_bits(1'b1, gap);
    endtask

    // stim[k] is sampled at posedge play_base+1+k; busy_log[k]/qd_log[k] are
    // the outputs right after that edge.
    task automatic play();
        for (int i = 0; i <= stim.size(); i++) begin
            @(negedge clk);
            if (i == 0) play_base = cyc;
            else begin busy_log.push_back(busy); qd_log.push_back(q_data); end
            if (i < stim.size()) begin d = stim[i]; reset_sync = rst_q[i]; end
            else begin d = 1'b1; reset_sync = 1'b0; end
        end
    endtask

    function automatic bit line_at(input int k);
        return (k < stim.size()) ? stim[k] : 1'b1;
    endfunction

    // Reference: walk the line by sample instants rather than by states.
    task automatic run_model();
        int k, e0, sk;
        logic [W-1:0] data;
        k = 0;
        while (k < stim.size()) begin
            if (line_at(k)) begin k++; continue; end
            e0 = k;
            if (line_at(e0 + HALF)) begin k = e0 + HALF + 1; continue; end
            for (int i = 0; i < W; i++) data[i] = line_at(e0 + HALF + (i + 1) * CPB);
            sk = e0 + HALF + (W + 1) * CPB;
            if (line_at(sk)) begin
                model_q = data;
                exp_q.push_back('{play_base + 1 + sk, 1'b0, data});
                k = sk + 1;
            end else begin
                exp_q.push_back('{play_base + 1 + sk, 1'b1, model_q});
                k = sk + 1;
                while (!line_at(k)) k++;
                k++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); reset_sync = 1'b1; d = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (q_data !== '0)    $display("FAIL reset_q_data: got %h want 0", q_data);   else passed++;
        checks++; if (q_valid !== 1'b0) $display("FAIL reset_q_valid: got %b want 0", q_valid); else passed++;
        checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
        checks++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", busy);       else passed++;
        d = 1'b1; reset_sync = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0 || act_q.size() != 0)
            $display("FAIL reset_no_frame: busy %b strobes %0d want 0/0", busy, act_q.size()); else passed++;
    endtask

    task automatic test_good_frame();
        ev_t a;
        clear_stim(); push_bits(1'b1, 3); push_frame(8'hA5, 1'b1, 12);
        play(); run_model();
        checks++; if (act_q.size() != exp_q.size()) $display("FAIL good_count: got %0d want %0d", act_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            a = (i < act_q.size()) ? act_q[i] : '0;
            checks++; if (a !== exp_q[i]) $display("FAIL good_ev%0d: got cyc=%0d err=%0b data=%h want cyc=%0d err=%0b data=%h", i, a.cyc, a.err, a.data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); else passed++;
        end
        a = (act_q.size() > 0) ? act_q[0] : '0;
        checks++; if (a.data !== 8'hA5 || a.err !== 1'b0) $display("FAIL good_data: got %h err %b want a5 err 0", a.data, a.err); else passed++;
        checks++; if (a.cyc + 1 - (play_base + 4) != LAT) $display("FAIL good_latency: got %0d want %0d", a.cyc + 1 - (play_base + 4), LAT); else passed++;
        checks++; if (busy_log[2] !== 1'b0 || busy_log[3] !== 1'b1) $display("FAIL good_busy_rise: got %b%b want 01", busy_log[2], busy_log[3]); else passed++;
        checks++; if (busy_log[3 + LAT - 2] !== 1'b1 || busy_log[3 + LAT - 1] !== 1'b0) $display("FAIL good_busy_fall: got %b%b want 10", busy_log[3 + LAT - 2], busy_log[3 + LAT - 1]); else passed++;
    endtask

    task automatic test_glitch();
        ev_t a;
        clear_stim(); push_bits(1'b1, 2); push_bits(1'b0, 1); push_bits(1'b1, 10);
        play(); run_model();
        checks++; if (act_q.size() != exp_q.size()) $display("FAIL glitch_count: got %0d want %0d", act_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            a = (i < act_q.size()) ? act_q[i] : '0;
            checks++; if (a !== exp_q[i]) $display("FAIL glitch_ev%0d: got cyc=%0d data=%h want cyc=%0d data=%h", i, a.cyc, a.data, exp_q[i].cyc, exp_q[i].data); else passed++;
        end
        checks++; if (busy_log[3] !== 1'b1 || busy_log[4] !== 1'b0) $display("FAIL glitch_busy: got %b%b want 10", busy_log[3], busy_log[4]); else passed++;
        checks++; if (qd_log[qd_log.size() - 1] !== 8'hA5) $display("FAIL glitch_q_data: got %h want a5", qd_log[qd_log.size() - 1]); else passed++;
    endtask

    task automatic test_frame_err();
        ev_t a;
        clear_stim(); push_bits(1'b1, 2); push_frame(8'h3C, 1'b0, 0); push_bits(1'b0, 10); push_bits(1'b1, 6);
        play(); run_model();
        checks++; if (act_q.size() != exp_q.size()) $display("FAIL ferr_count: got %0d want %0d", act_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            a = (i < act_q.size()) ? act_q[i] : '0;
            checks++; if (a !== exp_q[i]) $display("FAIL ferr_ev%0d: got cyc=%0d err=%0b data=%h want cyc=%0d err=%0b data=%h", i, a.cyc, a.err, a.data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); else passed++;
        end
        a = (act_q.size() > 0) ? act_q[0] : '0;
        checks++; if (a.err !== 1'b1 || a.data !== 8'hA5) $display("FAIL ferr_kind: got err %b data %h want 1 a5", a.err, a.data); else passed++;
        checks++; if (busy_log[51] !== 1'b1 || busy_log[52] !== 1'b0) $display("FAIL ferr_busy: got %b%b want 10", busy_log[51], busy_log[52]); else passed++;
    endtask

    task automatic test_back_to_back();
        ev_t a, b;
        clear_stim(); push_bits(1'b1, 2); push_frame(8'h01, 1'b1, 0); push_frame(8'hFF, 1'b1, 8);
        play(); run_model();
        checks++; if (act_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", act_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            a = (i < act_q.size()) ? act_q[i] : '0;
            checks++; if (a !== exp_q[i]) $display("FAIL b2b_ev%0d: got cyc=%0d data=%h want cyc=%0d data=%h", i, a.cyc, a.data, exp_q[i].cyc, exp_q[i].data); else passed++;
        end
        a = (act_q.size() > 0) ? act_q[0] : '0;
        b = (act_q.size() > 1) ? act_q[1] : '0;
        checks++; if (a.data !== 8'h01 || b.data !== 8'hFF) $display("FAIL b2b_data: got %h %h want 01 ff", a.data, b.data); else passed++;
        checks++; if (b.cyc - a.cyc != (W + 2) * CPB) $display("FAIL b2b_spacing: got %0d want %0d", b.cyc - a.cyc, (W + 2) * CPB); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        ev_t a;
        logic [W-1:0] v;
        v = 8'h5A;
        clear_stim(); push_bits(1'b1, 2); push_bits(1'b0, CPB);
        for (int i = 0; i < 4; i++) push_bits(v[i], CPB);
        push_bits(v[4], 2);
        rst_q[rst_q.size() - 1] = 1'b1;
        push_bits(1'b1, 2);
        play();
        checks++; if (act_q.size() != 0) $display("FAIL rstmid_strobe: got %0d strobes want 0", act_q.size()); else passed++;
        checks++; if (busy_log[22] !== 1'b1 || busy_log[23] !== 1'b0) $display("FAIL rstmid_busy: got %b%b want 10", busy_log[22], busy_log[23]); else passed++;
        checks++; if (qd_log[22] !== 8'hFF || qd_log[23] !== '0) $display("FAIL rstmid_q_data: got %h->%h want ff->00", qd_log[22], qd_log[23]); else passed++;
        model_q = '0;
        clear_stim(); push_bits(1'b1, 4); push_frame(v, 1'b1, 10);
        play(); run_model();
        checks++; if (act_q.size() != exp_q.size()) $display("FAIL rstmid_count: got %0d want %0d", act_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            a = (i < act_q.size()) ? act_q[i] : '0;
            checks++; if (a !== exp_q[i]) $display("FAIL rstmid_ev%0d: got cyc=%0d data=%h want cyc=%0d data=%h", i, a.cyc, a.data, exp_q[i].cyc, exp_q[i].data); else passed++;
        end
        checks++; if (qd_log[qd_log.size() - 1] !== 8'h5A) $display("FAIL rstmid_refill: got %h want 5a", qd_log[qd_log.size() - 1]); else passed++;
    endtask

    task automatic test_random();
        ev_t a;
        int r;
        clear_stim(); push_bits(1'b1, 2);
        for (int f = 0; f < 25; f++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                push_bits(1'b0, $urandom_range(1, HALF));
                push_bits(1'b1, $urandom_range(1, 4));
            end else if (r == 1) begin
                push_frame(W'($urandom), 1'b0, $urandom_range(1, 5));
            end else begin
                push_frame(W'($urandom), 1'b1, $urandom_range(0, 5));
            end
        end
        push_bits(1'b1, 12);
        play(); run_model();
        checks++; if (act_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", act_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            a = (i < act_q.size()) ? act_q[i] : '0;
            checks++; if (a !== exp_q[i]) $display("FAIL rand_ev%0d: got cyc=%0d err=%0b data=%h want cyc=%0d err=%0b data=%h", i, a.cyc, a.err, a.data, exp_q[i].cyc, exp_q[i].err, exp_q[i].data); else passed++;
        end
        checks++; if (qd_log[qd_log.size() - 1] !== model_q || busy_log[busy_log.size() - 1] !== 1'b0)
            $display("FAIL rand_final: got q_data %h busy %b want %h 0", qd_log[qd_log.size() - 1], busy_log[busy_log.size() - 1], model_q); else passed++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
